sc_stream_sched: RTL



---
 rtl/sc_stream_if.sv | 28 ++
 rtl/sc_stream_sched.sv | 114 +++++++++++
 2 files changed

// File: rtl/sc_stream_if.sv
// Operand-in / bitstream-out handshake bundle for the stochastic-computing stream scheduler.
interface sc_stream_if #(
    parameter int unsigned BITSTREAM = 64,
    parameter int unsigned QUANT     = 8
) ();
    localparam int unsigned CW = $clog2(BITSTREAM) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [QUANT-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_bit;
    logic             out_last;
    logic [CW-1:0]    out_quota;

    // Environment side: supplies operands and accepts stream bits
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_bit, out_last, out_quota
    );

    // Scheduler side
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_bit, out_last, out_quota
    );
endinterface

// File: rtl/sc_stream_sched.sv
// Converts a signed operand into a BITSTREAM-long stochastic bitstream carrying quota ones,
// either spread evenly (accumulator pattern) or unary (ones first).
module sc_stream_sched #(
    parameter int unsigned BITSTREAM = 64,
    parameter int unsigned QUANT     = 8,
    parameter int unsigned SPREAD    = 1
) (
    input  logic        clk,
    input  logic        rst,
    sc_stream_if.slave  bus,
    output logic        busy
);
    localparam int unsigned TW = $clog2(BITSTREAM);
    localparam int unsigned CW = TW + 1;
    localparam int unsigned AW = CW + 1;
    localparam int unsigned PW = QUANT + TW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_STREAM
    } state_e;

    state_e           state_q, state_d;
    logic [QUANT-1:0] data_q, data_d;
    logic [CW-1:0]    quota_q, quota_d;
    logic [TW-1:0]    cnt_q, cnt_d;
    logic [AW-1:0]    acc_q, acc_d;

    logic [QUANT-1:0] u_c;
    logic [PW-1:0]    prod_c;
    logic [CW-1:0]    quota_calc_c;
    logic [AW-1:0]    sum_c;
    logic             bit_c;
    logic             last_c;

    // Offset-binary of the signed operand is just the sign bit inverted
    assign u_c          = {~data_q[QUANT-1], data_q[QUANT-2:0]};
    assign prod_c       = PW'(u_c) * PW'(BITSTREAM) + PW'(2 ** (QUANT - 1));
    assign quota_calc_c = CW'(prod_c >> QUANT);

    assign sum_c  = acc_q + AW'(quota_q);
    assign bit_c  = (SPREAD != 0) ? (sum_c >= AW'(BITSTREAM)) : (CW'(cnt_q) < quota_q);
    assign last_c = (cnt_q == TW'(BITSTREAM - 1));
    assign busy   = (state_q != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            quota_q <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            quota_q <= quota_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        data_d        = data_q;
        quota_d       = quota_q;
        cnt_d         = cnt_q;
        acc_d         = acc_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_bit   = 1'b0;
        bus.out_last  = 1'b0;
        bus.out_quota = '0;

        case (state_q)
            S_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    data_d  = bus.in_data;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                quota_d = quota_calc_c;
                cnt_d   = '0;
                acc_d   = '0;
                state_d = S_STREAM;
            end
            S_STREAM: begin
                bus.out_valid = 1'b1;
                bus.out_bit   = bit_c;
                bus.out_last  = last_c;
                bus.out_quota = quota_q;
                // Opening in_ready on the accepted last beat lets the next operand skip IDLE
                bus.in_ready  = last_c && bus.out_ready;
                if (bus.out_ready) begin
                    cnt_d = cnt_q + TW'(1);
                    if (SPREAD != 0) begin
                        acc_d = bit_c ? (sum_c - AW'(BITSTREAM)) : sum_c;
                    end
                    if (last_c) begin
                        if (bus.in_valid) begin
                            data_d  = bus.in_data;
                            state_d = S_CALC;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule
